// File: rtl/valve_latch_if.sv
// Request handshake between the irrigation sequencer and valve_latch_driver.
// Signals:
//   req_valid   - sequencer presents req_pattern
//   req_ready   - driver is idle and will accept on this edge
//   req_pattern - requested latch states, sampled on acceptance
// Modports: master (sequencer side), slave (driver side).
interface valve_latch_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_pattern;

  modport master (
    output req_valid,
    output req_pattern,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_pattern,
    output req_ready
  );
endinterface

// File: rtl/valve_latch_driver.sv
// Command-side driver for a bank of JK valve latches. It accepts a target
// pattern and drives the J/K excitation for one clock. It then checks the Q
// feedback and re-drives on mismatch, up to MAX_RETRY extra attempts. The
// outcome is reported as a one-cycle done or err pulse.
//
// Ports:
//   clk, reset    - clock shared with the latch bank; async active-high reset
//   req           - valve_latch_if.slave request handshake
//   q_fb          - live Q outputs of the latch bank
//   j, k          - registered J/K excitation to the latch bank
//   busy          - high in DRIVE/CHECK
//   done / err    - one-cycle outcome pulses
//   err_bits      - target ^ q_fb at failure, held until the next acceptance
//
// Build option: define TOGGLE_EXCITE_EN to drive every changing bit with
// j=k=1 (toggle) instead of explicit set/reset excitation.
module valve_latch_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  valve_latch_if.slave     req,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [WIDTH-1:0]     j_q, j_d;
  logic [WIDTH-1:0]     k_q, k_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     err_bits_q, err_bits_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 accept;

  // J excitation for moving each latch from q toward t
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] q);
`ifdef TOGGLE_EXCITE_EN
    return t ^ q;
`else
    return t & ~q;
`endif
  endfunction

  // K excitation for moving each latch from q toward t
  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] q);
`ifdef TOGGLE_EXCITE_EN
    return t ^ q;
`else
    return ~t & q;
`endif
  endfunction

  assign accept = req.req_valid && req_ready_q;

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    retry_cnt_d = retry_cnt_q;
    j_d         = '0;
    k_d         = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_bits_d  = err_bits_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          target_d    = req.req_pattern;
          retry_cnt_d = '0;
          j_d         = excite_j(req.req_pattern, q_fb);
          k_d         = excite_k(req.req_pattern, q_fb);
          err_bits_d  = '0;
          state_d     = ST_DRIVE;
        end
      end
      // Latches sample j/k at the closing edge; j/k return to zero after it
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_cnt_q < RETRY_LIMIT) begin
          retry_cnt_d = retry_cnt_q + RETRY_W'(1);
          j_d         = excite_j(target_q, q_fb);
          k_d         = excite_k(target_q, q_fb);
          state_d     = ST_DRIVE;
        end else begin
          err_d      = 1'b1;
          err_bits_d = target_q ^ q_fb;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flops follow the next state so they line up with done/err
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Single register stage for the FSM and all outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      retry_cnt_q <= '0;
      j_q         <= '0;
      k_q         <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_bits_q  <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      retry_cnt_q <= retry_cnt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_bits_q  <= err_bits_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req.req_ready = req_ready_q;
  assign j             = j_q;
  assign k             = k_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_bits      = err_bits_q;

endmodule

// File: tb/tb_valve_latch_driver.sv
// Directed bench for valve_latch_driver with a behavioural JK latch bank
// (presettable, with a stuck-at-0 mask) closing the feedback loop.
module tb_valve_latch_driver;

  localparam int unsigned WIDTH = 4;

`ifdef TOGGLE_EXCITE_EN
  localparam logic [3:0] BASIC_J = 4'b1010, BASIC_K = 4'b1010;
  localparam logic [3:0] MIX_J   = 4'b1010, MIX_K   = 4'b1010;
  localparam logic [3:0] STK_J   = 4'b0001, STK_K   = 4'b0001;
  localparam logic [3:0] TGL_J   = 4'b0110, TGL_K   = 4'b0110;
  localparam logic [3:0] B2B1_J  = 4'b0011, B2B1_K  = 4'b0011;
  localparam logic [3:0] B2B2_J  = 4'b1111, B2B2_K  = 4'b1111;
`else
  localparam logic [3:0] BASIC_J = 4'b1010, BASIC_K = 4'b0000;
  localparam logic [3:0] MIX_J   = 4'b1000, MIX_K   = 4'b0010;
  localparam logic [3:0] STK_J   = 4'b0001, STK_K   = 4'b0000;
  localparam logic [3:0] TGL_J   = 4'b0100, TGL_K   = 4'b0010;
  localparam logic [3:0] B2B1_J  = 4'b0011, B2B1_K  = 4'b0000;
  localparam logic [3:0] B2B2_J  = 4'b1100, B2B2_K  = 4'b0011;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] q_fb, j, k, err_bits;
  logic             busy, done, err;

  logic [WIDTH-1:0] latch_q = '0;
  logic             preset_en = 1'b0;
  logic [WIDTH-1:0] preset_val = '0;
  logic [WIDTH-1:0] stuck0 = '0;
  logic             jk_overlap_seen = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  valve_latch_if #(.WIDTH(WIDTH)) req_if ();

  valve_latch_driver #(.WIDTH(WIDTH), .MAX_RETRY(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req_if.slave),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_bits (err_bits)
  );

  always #5 clk = ~clk;

  // JK latch bank: Q+ = J&~Q | ~K&Q, with stuck-at-0 bits forced low
  always @(posedge clk) begin
    if (preset_en) latch_q <= preset_val & ~stuck0;
    else           latch_q <= ((j & ~latch_q) | (~k & latch_q)) & ~stuck0;
  end
  assign q_fb = latch_q;

  always @(negedge clk) begin
    if ((j & k) != '0) jk_overlap_seen <= 1'b1;
  end

  task automatic preset(input logic [3:0] v);
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Present one request; returns at the negedge after the acceptance edge
  task automatic send(input logic [3:0] p);
    req_if.req_valid   = 1'b1;
    req_if.req_pattern = p;
    @(negedge clk);
    req_if.req_valid   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_pattern = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({j, k} !== 8'h00) begin n_bad++; $display("FAIL reset_jk got %b/%b want 0000/0000", j, k); end
    n_cmp++; if ({req_if.req_ready, busy, done, err} !== 4'b1000) begin n_bad++; $display("FAIL reset_status got rdy=%b busy=%b done=%b err=%b want 1000", req_if.req_ready, busy, done, err); end
    n_cmp++; if (err_bits !== 4'b0000) begin n_bad++; $display("FAIL reset_err_bits got %b want 0000", err_bits); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({req_if.req_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL reset_release got rdy=%b busy=%b want 10", req_if.req_ready, busy); end
  endtask

  task automatic test_basic;
    preset(4'b0000);
    send(4'b1010);
    n_cmp++; if ({j, k} !== {BASIC_J, BASIC_K}) begin n_bad++; $display("FAIL basic_drive got %b/%b want %b/%b", j, k, BASIC_J, BASIC_K); end
    n_cmp++; if ({busy, req_if.req_ready} !== 2'b10) begin n_bad++; $display("FAIL basic_busy got busy=%b rdy=%b want 10", busy, req_if.req_ready); end
    @(negedge clk);
    n_cmp++; if ({j, k, done} !== 9'b0) begin n_bad++; $display("FAIL basic_check_idle got j=%b k=%b done=%b want zeros", j, k, done); end
    @(negedge clk);
    n_cmp++; if ({done, err, req_if.req_ready, busy} !== 4'b1010) begin n_bad++; $display("FAIL basic_done got done=%b err=%b rdy=%b busy=%b want 1010", done, err, req_if.req_ready, busy); end
    n_cmp++; if (q_fb !== 4'b1010) begin n_bad++; $display("FAIL basic_latch got %b want 1010", q_fb); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_stuck;
    int drives;
    drives = 0;
    stuck0 = 4'b0001;
    preset(4'b0000);
    send(4'b0001);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      if (j === STK_J && k === STK_K) drives++;
      if (n == 8) begin
        n_cmp++; if ({err, done, req_if.req_ready} !== 3'b101) begin n_bad++; $display("FAIL stuck_err got err=%b done=%b rdy=%b want 101", err, done, req_if.req_ready); end
        n_cmp++; if (err_bits !== 4'b0001) begin n_bad++; $display("FAIL stuck_err_bits got %b want 0001", err_bits); end
      end else begin
        n_cmp++; if ({err, done} !== 2'b00) begin n_bad++; $display("FAIL stuck_no_pulse_%0d got err=%b done=%b want 00", n, err, done); end
      end
    end
    n_cmp++; if (drives !== 4) begin n_bad++; $display("FAIL stuck_drive_count got %0d want 4", drives); end
    n_cmp++; if (err_bits !== 4'b0001) begin n_bad++; $display("FAIL stuck_err_bits_hold got %b want 0001", err_bits); end
    stuck0 = 4'b0000;
  endtask

  task automatic test_mixed;
    preset(4'b0110);
    send(4'b1100);
    n_cmp++; if ({j, k} !== {MIX_J, MIX_K}) begin n_bad++; $display("FAIL mixed_drive got %b/%b want %b/%b", j, k, MIX_J, MIX_K); end
    n_cmp++; if (err_bits !== 4'b0000) begin n_bad++; $display("FAIL mixed_err_bits_clear got %b want 0000", err_bits); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL mixed_done got done=%b err=%b want 10", done, err); end
    n_cmp++; if (q_fb !== 4'b1100) begin n_bad++; $display("FAIL mixed_latch got %b want 1100", q_fb); end
  endtask

  task automatic test_noop;
    preset(4'b0101);
    send(4'b0101);
    n_cmp++; if ({j, k, busy} !== 9'b1) begin n_bad++; $display("FAIL noop_drive got j=%b k=%b busy=%b want 0000/0000/1", j, k, busy); end
    @(negedge clk);
    n_cmp++; if ({j, k, done} !== 9'b0) begin n_bad++; $display("FAIL noop_check got j=%b k=%b done=%b want zeros", j, k, done); end
    @(negedge clk);
    n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL noop_done got done=%b err=%b want 10", done, err); end
  endtask

  task automatic test_toggle;
    preset(4'b0011);
    send(4'b0101);
    n_cmp++; if ({j, k} !== {TGL_J, TGL_K}) begin n_bad++; $display("FAIL toggle_drive got %b/%b want %b/%b", j, k, TGL_J, TGL_K); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL toggle_done got done=%b err=%b want 10", done, err); end
    n_cmp++; if (q_fb !== 4'b0101) begin n_bad++; $display("FAIL toggle_latch got %b want 0101", q_fb); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    preset(4'b0000);
    send(4'b1010);
    n_cmp++; if (j !== BASIC_J) begin n_bad++; $display("FAIL rmid_drive got %b want %b", j, BASIC_J); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({j, k} !== 8'h00) begin n_bad++; $display("FAIL rmid_async_jk got %b/%b want 0000/0000", j, k); end
    n_cmp++; if ({busy, req_if.req_ready} !== 2'b01) begin n_bad++; $display("FAIL rmid_status got busy=%b rdy=%b want 01", busy, req_if.req_ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_no_pulse got %b want 0", seen); end
    n_cmp++; if (req_if.req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got %b want 1", req_if.req_ready); end
  endtask

  task automatic test_back_to_back;
    preset(4'b0000);
    req_if.req_valid   = 1'b1;
    req_if.req_pattern = 4'b0011;
    @(negedge clk);
    n_cmp++; if ({j, k} !== {B2B1_J, B2B1_K}) begin n_bad++; $display("FAIL b2b_first got %b/%b want %b/%b", j, k, B2B1_J, B2B1_K); end
    req_if.req_pattern = 4'b1111;
    @(negedge clk);
    req_if.req_pattern = 4'b1100;
    @(negedge clk);
    n_cmp++; if ({done, req_if.req_ready} !== 2'b11) begin n_bad++; $display("FAIL b2b_first_done got done=%b rdy=%b want 11", done, req_if.req_ready); end
    @(negedge clk);
    req_if.req_valid = 1'b0;
    n_cmp++; if ({j, k} !== {B2B2_J, B2B2_K}) begin n_bad++; $display("FAIL b2b_second got %b/%b want %b/%b", j, k, B2B2_J, B2B2_K); end
    n_cmp++; if ({done, busy} !== 2'b01) begin n_bad++; $display("FAIL b2b_second_busy got done=%b busy=%b want 01", done, busy); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL b2b_second_done got done=%b err=%b want 10", done, err); end
    n_cmp++; if (q_fb !== 4'b1100) begin n_bad++; $display("FAIL b2b_latch got %b want 1100", q_fb); end
  endtask

  task automatic test_jk_exclusive;
`ifndef TOGGLE_EXCITE_EN
    n_cmp++; if (jk_overlap_seen !== 1'b0) begin n_bad++; $display("FAIL jk_exclusive got overlap=%b want 0", jk_overlap_seen); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck();
    test_mixed();
    test_noop();
    test_toggle();
    test_reset_mid();
    test_back_to_back();
    test_jk_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
